// File: rtl/mpsoc_arb_pkg.sv
// Shared types and constants for the MPSoC shared-peripheral arbiters.
package mpsoc_arb_pkg;

  // Sequencer phases of one serialised slave transaction
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Latency counter width; covers slave latencies up to 7 cycles
  localparam int unsigned CNT_W = 3;

  // Default read data width of the shared slave
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/mpsoc_rr_pick.sv
// Combinational rotating-priority picker: the winner is the first set request
// bit scanning upward from last_i+1, wrapping modulo N_REQ.
module mpsoc_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  // One extra bit so last_i + k (at most 2*N_REQ-1) cannot overflow before wrap
  logic [IDX_W:0] cand;

  // Scan from farthest to nearest so the nearest requester after last_i wins
  always_comb begin
    grant_o = last_i;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (req_i[cand[IDX_W-1:0]]) begin
        grant_o = cand[IDX_W-1:0];
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpsoc_sysid_arbiter.sv
// Round-robin sequencer sharing one fixed-latency read-only slave among
// N_MASTERS masters; exactly one transaction in flight at a time.
module mpsoc_sysid_arbiter
  import mpsoc_arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 1,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SLAVE_LAT = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_read,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  output logic [N_MASTERS-1:0]          m_waitrequest,
  output logic [N_MASTERS-1:0]          m_readdatavalid,
  output logic [DATA_W-1:0]             m_readdata,
  output logic                          s_read,
  output logic [ADDR_W-1:0]             s_address,
  input  logic [DATA_W-1:0]             s_readdata
);

  localparam int IDX_W = $clog2(N_MASTERS);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      last_q;     // current/last granted master
  logic [CNT_W-1:0]      cnt_q;
  logic [N_MASTERS-1:0]  wait_q;
  logic [N_MASTERS-1:0]  rdv_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  sread_q;
  logic [ADDR_W-1:0]     saddr_q;

  logic [IDX_W-1:0]      grant_d;
  logic                  any_d;
  logic [N_MASTERS-1:0]  grant_oh_d;
  logic [N_MASTERS-1:0]  last_oh;
  logic [ADDR_W-1:0]     addr_arr [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_addr
    assign addr_arr[i] = m_address[i*ADDR_W +: ADDR_W];
  end

  mpsoc_rr_pick #(
    .N_REQ (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (m_read),
    .last_i  (last_q),
    .grant_o (grant_d),
    .any_o   (any_d)
  );

  assign grant_oh_d = N_MASTERS'(1) << grant_d;
  assign last_oh    = N_MASTERS'(1) << last_q;

  // Transaction sequencer; every output is a register so masters and slave
  // see glitch-free strobes. Strobes default low/high each cycle and are only
  // asserted in the one cycle their phase owns.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(N_MASTERS-1);
      cnt_q   <= '0;
      wait_q  <= '1;
      rdv_q   <= '0;
      rdata_q <= '0;
      sread_q <= 1'b0;
      saddr_q <= '0;
    end else begin
      wait_q  <= '1;
      rdv_q   <= '0;
      sread_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_d) begin
            last_q  <= grant_d;
            saddr_q <= addr_arr[grant_d];
            sread_q <= 1'b1;
            wait_q  <= ~grant_oh_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (SLAVE_LAT == 0) begin
            // combinational slave: data is valid alongside s_read
            rdata_q <= s_readdata;
            rdv_q   <= last_oh;
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= CNT_W'(SLAVE_LAT-1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= s_readdata;
            rdv_q   <= last_oh;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_waitrequest   = wait_q;
  assign m_readdatavalid = rdv_q;
  assign m_readdata      = rdata_q;
  assign s_read          = sread_q;
  assign s_address       = saddr_q;

endmodule

// File: tb/tb_mpsoc_sysid_arbiter.sv
// Bench for mpsoc_sysid_arbiter: two instances (slave latency 0 and 3) share
// one stimulus; a transaction-timeline model predicts every output each cycle.
module tb_mpsoc_sysid_arbiter;

  localparam int N  = 4;
  localparam int AW = 1;
  localparam int DW = 32;
  localparam logic [DW-1:0] JUNK  = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] WORD1 = 32'd1648782304;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  m_read = '0;
  logic [N*AW-1:0] m_address = '0;

  // instance with SLAVE_LAT=0
  logic [N-1:0]  wait0, rdv0;
  logic [DW-1:0] rdata0, srdata0;
  logic          sread0;
  logic [AW-1:0] saddr0;
  // instance with SLAVE_LAT=3
  logic [N-1:0]  wait3, rdv3;
  logic [DW-1:0] rdata3, srdata3;
  logic          sread3;
  logic [AW-1:0] saddr3;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;
  int cyc = 0;

  initial forever #5 clock = ~clock;

  mpsoc_sysid_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SLAVE_LAT(0)) dut0 (
    .clock(clock), .reset(reset), .m_read(m_read), .m_address(m_address),
    .m_waitrequest(wait0), .m_readdatavalid(rdv0), .m_readdata(rdata0),
    .s_read(sread0), .s_address(saddr0), .s_readdata(srdata0));

  mpsoc_sysid_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SLAVE_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .m_read(m_read), .m_address(m_address),
    .m_waitrequest(wait3), .m_readdatavalid(rdv3), .m_readdata(rdata3),
    .s_read(sread3), .s_address(saddr3), .s_readdata(srdata3));

  function automatic logic [DW-1:0] memrd(input logic [AW-1:0] a);
    return (a == 1'b1) ? WORD1 : '0;
  endfunction

  // Slaves: data is valid only in the cycle exactly LAT after the strobe
  assign srdata0 = sread0 ? memrd(saddr0) : JUNK;
  logic [2:0]    vp = '0;
  logic [AW-1:0] ap0 = '0, ap1 = '0, ap2 = '0;
  always @(posedge clock) begin
    vp  <= {vp[1:0], sread3};
    ap0 <= saddr3; ap1 <= ap0; ap2 <= ap1;
  end
  assign srdata3 = vp[2] ? memrd(ap2) : JUNK;

  // ---------------- model: transaction timeline per instance ----------------
  bit            busy   [2];
  int            start  [2];
  int            last   [2];
  logic [AW-1:0] saddr_e[2];
  logic [DW-1:0] rdata_e[2];
  logic [N-1:0]  wait_e [2];
  logic [N-1:0]  rdv_e  [2];
  logic          sread_e[2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int rr(input logic [N-1:0] req, input int lst);
    for (int k = 1; k <= N; k++)
      if (req[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  // Advance the model over the clock edge that ends cycle 'cyc'
  task automatic step(input int d);
    int g;
    int lt;
    lt = lat_of(d);
    if (reset) begin
      busy[d] = 0; last[d] = N-1; rdata_e[d] = '0; saddr_e[d] = '0;
    end else begin
      if (busy[d] && cyc == start[d] + 1 + lt) rdata_e[d] = memrd(saddr_e[d]);
      if (!busy[d] || cyc >= start[d] + 3 + lt) begin
        g = rr(m_read, last[d]);
        if (g >= 0) begin
          busy[d] = 1; start[d] = cyc; last[d] = g;
          saddr_e[d] = m_address[g*AW +: AW];
        end else begin
          busy[d] = 0;
        end
      end
    end
  endtask

  task automatic predict(input int d);
    bit issue, resp;
    issue = busy[d] && (cyc == start[d] + 1);
    resp  = busy[d] && (cyc == start[d] + 2 + lat_of(d));
    wait_e[d] = '1;
    rdv_e[d]  = '0;
    if (issue) wait_e[d][last[d]] = 1'b0;
    if (resp)  rdv_e[d][last[d]]  = 1'b1;
    sread_e[d] = issue;
  endtask

  initial begin : model
    forever begin
      @(posedge clock);
      for (int d = 0; d < 2; d++) step(d);
      cyc++;
      for (int d = 0; d < 2; d++) predict(d);
    end
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [N-1:0] w, input logic [N-1:0] r,
                         input logic sr, input logic [AW-1:0] sa, input logic [DW-1:0] rd);
    string p;
    p = $sformatf("lat%0d", lat_of(d));
    check({p, " waitrequest"}, DW'(w), DW'(wait_e[d]));
    check({p, " readdatavalid"}, DW'(r), DW'(rdv_e[d]));
    check({p, " s_read"}, DW'(sr), DW'(sread_e[d]));
    check({p, " s_address"}, DW'(sa), DW'(saddr_e[d]));
    check({p, " readdata"}, rd, rdata_e[d]);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial begin : compare
    forever begin
      @(negedge clock);
      if (chk_en) begin
        cmp_dut(0, wait0, rdv0, sread0, saddr0, rdata0);
        cmp_dut(1, wait3, rdv3, sread3, saddr3, rdata3);
      end
    end
  end

  task automatic nx(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin : stim
    @(posedge clock);
    chk_en = 1;
    nx(2);
    check("reset waitrequest", DW'(wait0), DW'(4'hF));
    check("reset s_read", DW'(sread3), 0);
    check("reset readdata", rdata3, 0);
    reset = 1'b0;
    nx(1);

    // single read: master 2, address 1
    m_address = 4'b0100; m_read = 4'b0100;
    nx(1);
    check("single accept wait", DW'(wait0), DW'(4'b1011));
    check("single s_read", DW'(sread0), 1);
    m_read = '0;
    nx(1);
    check("single rdv", DW'(rdv0), DW'(4'b0100));
    check("single data", rdata0, WORD1);
    nx(3);
    check("single lat3 rdv", DW'(rdv3), DW'(4'b0100));
    nx(1);

    // address 0 read by master 0
    m_address = '0; m_read = 4'b0001;
    nx(1);
    m_read = '0;
    nx(1);
    check("addr0 rdv", DW'(rdv0), DW'(4'b0001));
    check("addr0 data", rdata0, 0);
    nx(4);

    // latency 3: master 1, address 1
    m_address = 4'b0010; m_read = 4'b0010;
    nx(1);
    check("lat s_read issue", DW'(sread3), 1);
    check("lat accept wait", DW'(wait3), DW'(4'b1101));
    m_read = '0;
    for (int k = 0; k < 3; k++) begin
      nx(1);
      check("lat s_read idle", DW'(sread3), 0);
      check("lat early rdv", DW'(rdv3), 0);
    end
    nx(1);
    check("lat rdv", DW'(rdv3), DW'(4'b0010));
    check("lat data", rdata3, WORD1);
    nx(1);

    // withdrawn request: master 3 pulses while master 0 is in service
    m_address = '0; m_read = 4'b0001;
    nx(1);
    m_read = '0;
    nx(1);
    m_read = 4'b1000;
    nx(1);
    m_read = '0;
    for (int k = 0; k < 8; k++) begin
      check("withdrawn rdv3", DW'(rdv0[3] | rdv3[3]), 0);
      check("withdrawn wait3", DW'(wait0[3] & wait3[3]), 1);
      nx(1);
    end

    // contention: all masters request from reset onward
    reset = 1'b1; m_address = 4'b1010; m_read = 4'b1111;
    nx(1);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nx((k == 0) ? 1 : 3);
      check("rr grant order", DW'(wait0), DW'(~(4'b0001 << (k % 4)) & 4'hF));
    end
    nx(8);
    m_read = '0;
    nx(8);

    // reset during WAIT of the latency-3 instance
    m_address = 4'b0010; m_read = 4'b0010;
    nx(1);
    m_read = '0;
    nx(1);
    reset = 1'b1;
    nx(1);
    reset = 1'b0;
    check("mid reset wait", DW'(wait3), DW'(4'hF));
    check("mid reset s_read", DW'(sread3), 0);
    check("mid reset rdv", DW'(rdv3), 0);
    m_read = 4'b1010;
    nx(1);
    check("post reset grant", DW'(wait3), DW'(4'b1101));
    check("post reset grant lat0", DW'(wait0), DW'(4'b1101));
    m_read = '0;
    nx(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
